// File: rtl/memscan_pkg.sv
// Shared state encoding and default widths for the memscan read-scanner.
package memscan_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned KEY_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/memscan_rd_pipe.sv
// Valid-bit delay line: the retire strobe lines up with read data DEPTH cycles after the address.
module memscan_rd_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    output logic retire
);

    logic [DEPTH-1:0] vld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
        end else begin
            vld[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    assign retire = vld[DEPTH-1];

endmodule

// File: rtl/memscan.sv
// Scans n memory locations from base m and counts bytes equal to key c.
// Optional MEMSCAN_CHECKSUM_EN adds a checksum output of all retired bytes.
module memscan
    import memscan_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned KEY_W        = KEY_W_DEF,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] m,
    input  logic [31:0]       c,
    input  logic [ADDR_W-1:0] n,
    output logic              finish,
    output logic [ADDR_W-1:0] return_val,
`ifdef MEMSCAN_CHECKSUM_EN
    output logic [ADDR_W-1:0] checksum,
`endif
    output logic [ADDR_W-1:0] memory_controller_address,
    output logic              memory_controller_write_enable,
    output logic [DATA_W-1:0] memory_controller_in,
    input  logic [DATA_W-1:0] memory_controller_out
);

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] n_r;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] count;
    logic [KEY_W-1:0]  key;
    logic [1:0]        drain_cnt;
    logic              addr_valid;
    logic              retire;
    logic              hit;
    logic [ADDR_W-1:0] count_next;
    logic              unused_bits;

    assign memory_controller_write_enable = 1'b0;
    assign memory_controller_in           = '0;
    assign unused_bits = ^{c[31:KEY_W], memory_controller_out[DATA_W-1:KEY_W]};

    memscan_rd_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_rd_pipe (
        .clk    (clk),
        .reset  (reset),
        .push   (addr_valid),
        .retire (retire)
    );

    // Count includes the word retiring this cycle, so DONE can latch the final total.
    assign hit        = retire && (memory_controller_out[KEY_W-1:0] == key);
    assign count_next = count + ADDR_W'(hit);

`ifdef MEMSCAN_CHECKSUM_EN
    logic [ADDR_W-1:0] sum;
    logic [ADDR_W-1:0] sum_next;

    assign sum_next = sum + (retire ? ADDR_W'(memory_controller_out[KEY_W-1:0]) : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum      <= '0;
            checksum <= '0;
        end else begin
            sum <= sum_next;
            if (state == IDLE && start) begin
                sum <= '0;
            end
            if (state == DONE) begin
                checksum <= sum_next;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                     <= IDLE;
            finish                    <= 1'b0;
            return_val                <= '0;
            memory_controller_address <= '0;
            base                      <= '0;
            n_r                       <= '0;
            idx                       <= '0;
            count                     <= '0;
            key                       <= '0;
            drain_cnt                 <= '0;
            addr_valid                <= 1'b0;
        end else begin
            finish     <= 1'b0;
            addr_valid <= 1'b0;
            count      <= count_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        base  <= m;
                        key   <= c[KEY_W-1:0];
                        n_r   <= n;
                        count <= '0;
                        idx   <= '0;
                        state <= (n == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    memory_controller_address <= base + idx;
                    addr_valid                <= 1'b1;
                    idx                       <= idx + ADDR_W'(1);
                    if (idx == n_r - ADDR_W'(1)) begin
                        drain_cnt <= 2'(READ_LATENCY - 1);
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'd0) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                DONE: begin
                    return_val <= count_next;
                    finish     <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memscan.sv
// Directed bench for memscan: one instance at read latency 1, one at read latency 3.
module tb_memscan;

    logic        clk;
    logic        reset;

    logic        start,  start3;
    logic [31:0] m, c, n, m3, c3, n3;
    logic        finish, finish3;
    logic [31:0] return_val, return_val3;
    logic [31:0] addr, addr3;
    logic        we, we3;
    logic [31:0] din, din3, dout, dout3;
`ifdef MEMSCAN_CHECKSUM_EN
    logic [31:0] checksum, checksum3;
`endif

    logic [7:0] ram  [0:63];
    logic [7:0] ram3 [0:63];
    logic [7:0] q1, r1, r2, r3;

    int checks;
    int failures;
    int we_bad;

    memscan #(.READ_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .m(m), .c(c), .n(n),
        .finish(finish), .return_val(return_val),
`ifdef MEMSCAN_CHECKSUM_EN
        .checksum(checksum),
`endif
        .memory_controller_address(addr),
        .memory_controller_write_enable(we),
        .memory_controller_in(din),
        .memory_controller_out(dout)
    );

    memscan #(.READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .m(m3), .c(c3), .n(n3),
        .finish(finish3), .return_val(return_val3),
`ifdef MEMSCAN_CHECKSUM_EN
        .checksum(checksum3),
`endif
        .memory_controller_address(addr3),
        .memory_controller_write_enable(we3),
        .memory_controller_in(din3),
        .memory_controller_out(dout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: 64-entry RAM indexed by low address bits, junk in the upper data bits.
    always @(posedge clk) begin
        q1 <= ram[addr[5:0]];
        r1 <= ram3[addr3[5:0]];
        r2 <= r1;
        r3 <= r2;
    end
    assign dout  = {24'hA5C3E1, q1};
    assign dout3 = {24'h5A3C1E, r3};

    always @(negedge clk) begin
        if (reset === 1'b1 && (we !== 1'b0 || we3 !== 1'b0 || din !== 32'd0 || din3 !== 32'd0))
            we_bad++;
    end

    task automatic run_scan(input logic [31:0] mm, input logic [31:0] cc, input logic [31:0] nn,
                            input logic [31:0] exp_rv, input logic [31:0] exp_cks, input string tag);
        int got;
        int exp_cyc;
        logic [31:0] prev_addr;
        logic [31:0] ea;
        exp_cyc = (nn == 0) ? 1 : int'(nn) + 2;
        got = -1;
        @(posedge clk); #1;
        m = mm; c = cc; n = nn; start = 1'b1;
        prev_addr = addr;
        @(posedge clk); #1;
        start = 1'b0; m = 32'hDEAD_BEEF; c = 32'h0; n = 32'h7;
        for (int t = 1; t <= 80; t++) begin
            @(posedge clk); #1;
            if (t <= int'(nn)) begin
                ea = mm + 32'(t - 1);
                checks++;
                if (addr !== ea) begin
                    failures++;
                    $display("FAIL %s addr[%0d]: got %h expected %h", tag, t - 1, addr, ea);
                end
            end
            if (nn == 0 && t == 1) begin
                checks++;
                if (addr !== prev_addr) begin
                    failures++;
                    $display("FAIL %s addr_hold: got %h expected %h", tag, addr, prev_addr);
                end
            end
            if (finish === 1'b1) begin
                got = t;
                break;
            end
        end
        checks++;
        if (got != exp_cyc) begin
            failures++;
            $display("FAIL %s finish_cycle: got %0d expected %0d", tag, got, exp_cyc);
        end
        checks++;
        if (return_val !== exp_rv) begin
            failures++;
            $display("FAIL %s return_val: got %0d expected %0d", tag, return_val, exp_rv);
        end
`ifdef MEMSCAN_CHECKSUM_EN
        checks++;
        if (checksum !== exp_cks) begin
            failures++;
            $display("FAIL %s checksum: got %h expected %h", tag, checksum, exp_cks);
        end
`else
        if (exp_cks == 32'hFFFF_FFFF) $display("note: %s", tag);
`endif
        @(posedge clk); #1;
        checks++;
        if (finish !== 1'b0 || return_val !== exp_rv) begin
            failures++;
            $display("FAIL %s finish_pulse: finish=%b rv=%0d expected finish=0 rv=%0d", tag, finish, return_val, exp_rv);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (finish !== 1'b0 || return_val !== 32'd0 || addr !== 32'd0 || finish3 !== 1'b0 || return_val3 !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: finish=%b rv=%0d addr=%h expected 0/0/0", finish, return_val, addr);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_count_ramp();
        for (int i = 0; i < 64; i++) ram[i] = 8'(i);
        run_scan(32'd0, 32'h05, 32'd32, 32'd1, 32'd496, "ramp");
    endtask

    task automatic test_all_match();
        for (int i = 0; i < 64; i++) ram[i] = 8'h00;
        for (int i = 4; i < 12; i++) ram[i] = 8'hAA;
        run_scan(32'd4, 32'h1AA, 32'd8, 32'd8, 32'h550, "all_match");
    endtask

    task automatic test_zero_len();
        run_scan(32'd7, 32'h00, 32'd0, 32'd0, 32'd0, "zero_len");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 64; i++) ram[i] = 8'h00;
        ram[62] = 8'h11; ram[63] = 8'h22; ram[0] = 8'h11; ram[1] = 8'h33;
        run_scan(32'hFFFF_FFFE, 32'h11, 32'd4, 32'd2, 32'h77, "wrap");
    endtask

    task automatic test_abort();
        int fin_seen;
        for (int i = 0; i < 64; i++) ram[i] = 8'(i);
        @(posedge clk); #1;
        m = 32'd0; c = 32'h01; n = 32'd16; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (finish !== 1'b0 || return_val !== 32'd0 || addr !== 32'd0) begin
            failures++;
            $display("FAIL abort_async: finish=%b rv=%0d addr=%h expected 0/0/0", finish, return_val, addr);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        fin_seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (finish === 1'b1) fin_seen++;
        end
        checks++;
        if (fin_seen != 0) begin
            failures++;
            $display("FAIL abort_no_finish: got %0d pulses expected 0", fin_seen);
        end
        run_scan(32'd0, 32'h01, 32'd2, 32'd1, 32'd1, "after_abort");
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        int extra;
        for (int i = 0; i < 64; i++) ram3[i] = 8'(i);
        t1 = -1; t2 = -1; extra = 0;
        @(posedge clk); #1;
        m3 = 32'd0; c3 = 32'h01; n3 = 32'd3; start3 = 1'b1;
        @(posedge clk); #1;
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk); #1;
            if (finish3 === 1'b1) begin t1 = t; break; end
        end
        checks++;
        if (t1 != 7) begin
            failures++;
            $display("FAIL b2b_first_finish: got %0d expected 7", t1);
        end
        checks++;
        if (return_val3 !== 32'd1) begin
            failures++;
            $display("FAIL b2b_first_rv: got %0d expected 1", return_val3);
        end
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk); #1;
            if (finish3 === 1'b1) begin t2 = t; break; end
        end
        start3 = 1'b0;
        checks++;
        if (t2 != 8) begin
            failures++;
            $display("FAIL b2b_second_gap: got %0d expected 8", t2);
        end
        checks++;
        if (return_val3 !== 32'd1) begin
            failures++;
            $display("FAIL b2b_second_rv: got %0d expected 1", return_val3);
        end
`ifdef MEMSCAN_CHECKSUM_EN
        checks++;
        if (checksum3 !== 32'd3) begin
            failures++;
            $display("FAIL b2b_checksum: got %0d expected 3", checksum3);
        end
`endif
        repeat (15) begin
            @(posedge clk); #1;
            if (finish3 === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL b2b_no_third: got %0d pulses expected 0", extra);
        end
    endtask

    initial begin
        checks = 0; failures = 0; we_bad = 0;
        reset = 1'b0;
        start = 1'b0; m = '0; c = '0; n = '0;
        start3 = 1'b0; m3 = '0; c3 = '0; n3 = '0;
        for (int i = 0; i < 64; i++) begin
            ram[i] = 8'h00;
            ram3[i] = 8'h00;
        end
        q1 = 8'h00; r1 = 8'h00; r2 = 8'h00; r3 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_count_ramp();
        test_all_match();
        test_zero_len();
        test_wrap();
        test_abort();
        test_back_to_back();
        checks++;
        if (we_bad != 0) begin
            failures++;
            $display("FAIL write_enable_tied: got %0d bad cycles expected 0", we_bad);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
